aq_djpeg_mcu_seq: RTL and testbench
===================================

Name: aq_djpeg_mcu_seq

Overview:
MCU-level scheduler for the JPEG YCbCr output stage. It tracks which colour block (Y0..Y3/Cb/Cr) the IDCT is delivering and how many MCUs are buffered in the YCbCr double-bank memory. It also tracks the MCU X/Y position being converted, gates the decoder's next-block request and signals end of frame. It sits between the IDCT/zigzag output and the YCbCr memory / YCbCr-to-RGB converter, and replaces ad-hoc colour and block counting.

Parameters:
BANKS, 2, number of MCU buffers in the YCbCr memory (1..3)
CW, 12, width of MCU column/row counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ProcessInit  in  1  start-of-image pulse; clears all state, samples config
JpegComp  in  3  component count (1 = grey, 3 = YCbCr)
SubSamplingW  in  2  horizontal luma factor (1 or 2)
SubSamplingH  in  2  vertical luma factor (1 or 2)
ImageWidth  in  16  pixels
ImageHeight  in  16  pixels
BlockDone  in  1  pulse: one 8x8 block fully written (last page, last count)
ConvertDone  in  1  pulse: converter finished reading one MCU bank
BlockColor  out  3  colour code of block currently being written
BlockReq  out  1  decoder may start next block
McuX  out  CW  MCU column being converted
McuY  out  CW  MCU row being converted
McuCols  out  CW  MCUs per row
McuRows  out  CW  MCU rows
McuReady  out  1  pulse: a complete MCU has been stored
FrameDone  out  1  level: final MCU converted
Busy  out  1  sequencer active
ErrOverrun  out  1  sticky: BlockDone received while BlockReq low

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0; counters 0; config regs 0. Reset overrides ProcessInit and every other input.
- States: IDLE -> SETUP on ProcessInit; SETUP -> RUN after 1 cycle; RUN -> DONE when last MCU converted; DONE -> SETUP on ProcessInit. ProcessInit in any state restarts at SETUP and clears counters and ErrOverrun.
- SETUP: latch config. grey = (JpegComp!=3); grey forces W=H=1. shW=3+(W==2), shH=3+(H==2). McuCols=(ImageWidth+(1<<shW)-1)>>shW, McuRows likewise from ImageHeight. Results truncate to CW bits. A zero dimension gives zero: RUN is skipped and the block goes straight to DONE.
- Colour order per MCU:
  - grey: 0 only
  - 4:4:4: 0,4,5
  - 4:2:2 (W2H1): 0,1,4,5
  - 4:4:0 (W1H2): 0,2,4,5
  - 4:2:0: 0,1,2,3,4,5
- BlockColor advances on each BlockDone and wraps to 0 after the last code. McuReady pulses 1 cycle after the BlockDone of the last block.
- InFlight counter (0..BANKS): +1 on McuReady, -1 on ConvertDone. When both occur in the same cycle the count is unchanged. ConvertDone at InFlight=0 is ignored.
- BlockReq = RUN && (InFlight<BANKS || BlockColor!=0) && !stored_all. stored_all is set once McuCols*McuRows MCUs have been stored, tracked with a column/row store counter (no multiplier).
- BlockDone while BlockReq=0 sets ErrOverrun (sticky). The block is still counted.
- McuX/McuY advance on ConvertDone: McuX+1, wrapping to 0 at McuCols-1 with McuY+1. On the last MCU (McuX=McuCols-1, McuY=McuRows-1) go to DONE. FrameDone=1 and McuX/McuY hold their values.
- Busy = state in {SETUP,RUN}.
- All outputs are registered. Latency from BlockDone to BlockColor update is 1 cycle.

Decomposition:
- Shared package aq_djpeg_pkg: colour-code constants (Y0=0, Y1=1, Y2=2, Y3=3, CB=4, CR=5) and state encodings, reused by the YCbCr memory and the converter.
- One sub-module, aq_djpeg_mcu_dim: pure function block computing McuCols/McuRows from width, height and subsampling. Registered in SETUP.

Test Plan:
- 4:2:0, 32x16 image, 12 BlockDone pulses with ConvertDone after each McuReady -> BlockColor 0,1,2,3,4,5,0..; McuCols=2, McuRows=1; McuX 0->1; FrameDone after 2nd ConvertDone.
- Grey, 17x9 image -> McuCols=3, McuRows=2; BlockColor stays 0; 6 MCUs then FrameDone; McuY reaches 1.
- 4:2:2, BANKS=2, withhold ConvertDone -> BlockReq drops after 8 blocks (2 MCUs). A 9th BlockDone sets ErrOverrun=1. One ConvertDone re-raises BlockReq next cycle.
- McuReady and ConvertDone coincident at InFlight=1 -> InFlight stays 1; BlockReq stays 1.
- ProcessInit mid-frame (McuX=1, ErrOverrun=1) -> next cycle SETUP; McuX=0, ErrOverrun=0, BlockColor=0.
- rst=1 asserted during RUN for 1 cycle -> all outputs 0 on the next edge, state IDLE; subsequent BlockDone ignored until ProcessInit.

Source files
------------

// File: rtl/aq_djpeg_pkg.sv
// aq_djpeg_pkg: shared colour codes, sequencer state and MCU layout encodings, colour-order helpers
package aq_djpeg_pkg;
  localparam logic [2:0] Y0 = 3'd0, Y1 = 3'd1, Y2 = 3'd2, Y3 = 3'd3, CB = 3'd4, CR = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} seq_state_e;
  typedef enum logic [2:0] {M_GREY, M_444, M_422, M_440, M_420} mcu_mode_e;
  function automatic logic last_color(mcu_mode_e m, logic [2:0] c);
    return m == M_GREY || c == CR;
  endfunction
  function automatic logic [2:0] next_color(mcu_mode_e m, logic [2:0] c);
    logic [2:0] last_y;
    last_y = m == M_420 ? Y3 : m == M_440 ? Y2 : m == M_422 ? Y1 : Y0;
    return last_color(m, c) ? Y0 : c == CB ? CR : c == last_y ? CB : m == M_440 ? c + 3'd2 : c + 3'd1;
  endfunction
endpackage

// File: rtl/aq_djpeg_mcu_seq_if.sv
// aq_djpeg_mcu_seq_if: block/convert handshake (BlockDone,ConvertDone in; BlockColor,BlockReq,McuReady,McuX,McuY out)
interface aq_djpeg_mcu_seq_if #(parameter int CW = 12);
  logic BlockDone, ConvertDone, BlockReq, McuReady;
  logic [2:0] BlockColor;
  logic [CW-1:0] McuX, McuY;
  modport master(output BlockDone, ConvertDone, input BlockReq, McuReady, BlockColor, McuX, McuY);
  modport slave(input BlockDone, ConvertDone, output BlockReq, McuReady, BlockColor, McuX, McuY);
endinterface

// File: rtl/aq_djpeg_mcu_dim.sv
// aq_djpeg_mcu_dim: MCU grid size from image size; wide/tall select 16-pixel MCUs, outputs McuCols/McuRows
module aq_djpeg_mcu_dim #(parameter int CW = 12) (
  input  logic [15:0]   ImageWidth,
  input  logic [15:0]   ImageHeight,
  input  logic          wide,
  input  logic          tall,
  output logic [CW-1:0] McuCols,
  output logic [CW-1:0] McuRows
);
  logic [16:0] w_sum, h_sum;
  always_comb begin
    w_sum = {1'b0, ImageWidth} + (wide ? 17'd15 : 17'd7);
    h_sum = {1'b0, ImageHeight} + (tall ? 17'd15 : 17'd7);
    McuCols = CW'(wide ? w_sum >> 4 : w_sum >> 3);
    McuRows = CW'(tall ? h_sum >> 4 : h_sum >> 3);
  end
endmodule

// File: rtl/aq_djpeg_mcu_seq.sv
// aq_djpeg_mcu_seq: MCU scheduler; ProcessInit+config in, bus handshake, McuCols/McuRows/FrameDone/Busy/ErrOverrun out
module aq_djpeg_mcu_seq
  import aq_djpeg_pkg::*;
#(
  parameter int BANKS = 2,
  parameter int CW    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ProcessInit,
  input  logic [2:0]           JpegComp,
  input  logic [1:0]           SubSamplingW,
  input  logic [1:0]           SubSamplingH,
  input  logic [15:0]          ImageWidth,
  input  logic [15:0]          ImageHeight,
  aq_djpeg_mcu_seq_if.slave    bus,
  output logic [CW-1:0]        McuCols,
  output logic [CW-1:0]        McuRows,
  output logic                 FrameDone,
  output logic                 Busy,
  output logic                 ErrOverrun
);
  seq_state_e state_q, state_d;
  mcu_mode_e mode_q, mode_d, mode_in;
  logic [CW-1:0] cols_q, cols_d, rows_q, rows_d, x_q, x_d, y_q, y_d, sx_q, sx_d, sy_q, sy_d, dim_cols, dim_rows;
  logic [2:0] color_q, color_d;
  logic [1:0] infl_q, infl_d;
  logic req_q, req_d, rdy_q, rdy_d, err_q, err_d, done_q, done_d, busy_q, busy_d, stored_q, stored_d;
  logic grey, wide, tall, run, blk, conv, last_x, last_y, last_mcu, st, st_x, st_y;
  aq_djpeg_mcu_dim #(.CW(CW)) u_dim (
    .ImageWidth(ImageWidth), .ImageHeight(ImageHeight), .wide(wide), .tall(tall),
    .McuCols(dim_cols), .McuRows(dim_rows)
  );
  always_comb begin
    grey = JpegComp != 3'd3;
    wide = !grey && SubSamplingW == 2'd2;
    tall = !grey && SubSamplingH == 2'd2;
    mode_in = grey ? M_GREY : wide && tall ? M_420 : wide ? M_422 : tall ? M_440 : M_444;
    run = state_q == S_RUN;
    blk = run && bus.BlockDone;
    conv = run && bus.ConvertDone && infl_q != 2'd0;
    last_x = x_q == cols_q - CW'(1);
    last_y = y_q == rows_q - CW'(1);
    last_mcu = conv && last_x && last_y;
    st = blk && last_color(mode_q, color_q) && !stored_q;
    st_x = sx_q == cols_q - CW'(1);
    st_y = sy_q == rows_q - CW'(1);
    state_d = ProcessInit ? S_SETUP
            : state_q == S_SETUP ? (dim_cols == '0 || dim_rows == '0 ? S_DONE : S_RUN)
            : last_mcu ? S_DONE : state_q;
    mode_d = ProcessInit ? M_GREY : state_q == S_SETUP ? mode_in : mode_q;
    cols_d = ProcessInit ? '0 : state_q == S_SETUP ? dim_cols : cols_q;
    rows_d = ProcessInit ? '0 : state_q == S_SETUP ? dim_rows : rows_q;
    color_d = ProcessInit ? Y0 : blk ? next_color(mode_q, color_q) : color_q;
    rdy_d = !ProcessInit && blk && last_color(mode_q, color_q);
    // McuReady of the previous cycle fills a bank; a simultaneous valid ConvertDone cancels it out
    infl_d = ProcessInit ? 2'd0
           : rdy_q && !conv && infl_q < 2'(BANKS) ? infl_q + 2'd1
           : conv && !rdy_q ? infl_q - 2'd1 : infl_q;
    sx_d = ProcessInit ? '0 : st ? (st_x ? '0 : sx_q + CW'(1)) : sx_q;
    sy_d = ProcessInit ? '0 : st && st_x ? sy_q + CW'(1) : sy_q;
    stored_d = !ProcessInit && (stored_q || (st && st_x && st_y));
    x_d = ProcessInit ? '0 : conv && !last_mcu ? (last_x ? '0 : x_q + CW'(1)) : x_q;
    y_d = ProcessInit ? '0 : conv && last_x && !last_y ? y_q + CW'(1) : y_q;
    err_d = !ProcessInit && (err_q || (blk && !req_q));
    // a partly written MCU always owns a bank, so only a fresh MCU waits for a free one
    req_d = state_d == S_RUN && (infl_d < 2'(BANKS) || color_d != Y0) && !stored_d;
    done_d = state_d == S_DONE;
    busy_d = state_d == S_SETUP || state_d == S_RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q <= M_GREY;
      cols_q <= '0;
      rows_q <= '0;
      x_q <= '0;
      y_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      color_q <= Y0;
      infl_q <= 2'd0;
      req_q <= 1'b0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      stored_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      cols_q <= cols_d;
      rows_q <= rows_d;
      x_q <= x_d;
      y_q <= y_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      color_q <= color_d;
      infl_q <= infl_d;
      req_q <= req_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
      done_q <= done_d;
      busy_q <= busy_d;
      stored_q <= stored_d;
    end
  end
  assign bus.BlockColor = color_q;
  assign bus.BlockReq = req_q;
  assign bus.McuReady = rdy_q;
  assign bus.McuX = x_q;
  assign bus.McuY = y_q;
  assign McuCols = cols_q;
  assign McuRows = rows_q;
  assign FrameDone = done_q;
  assign Busy = busy_q;
  assign ErrOverrun = err_q;
endmodule

// File: tb/tb_aq_djpeg_mcu_seq.sv
// tb_aq_djpeg_mcu_seq: directed scenarios plus randomized frames against a count-based reference model
module tb_aq_djpeg_mcu_seq;
  localparam int CW = 12, BANKS = 2;
  logic clk = 0, rst = 1, pi = 0;
  logic [2:0] comp = 0;
  logic [1:0] ssw = 1, ssh = 1;
  logic [15:0] iw = 0, ih = 0;
  logic [CW-1:0] cols, rows;
  logic fdone, busy, err;
  int n_chk = 0, n_fail = 0;
  // reference model: 0 idle, 1 setup, 2 run, 3 done; progress kept as plain counts
  int m_state = 0, m_idx = 0, m_infl = 0, m_stored = 0, m_conv = 0, m_cols = 0, m_rows = 0;
  bit m_req = 0, m_rdy = 0, m_err = 0;
  int m_seq[$];
  aq_djpeg_mcu_seq_if #(.CW(CW)) bus();
  aq_djpeg_mcu_seq #(.BANKS(BANKS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ProcessInit(pi), .JpegComp(comp), .SubSamplingW(ssw), .SubSamplingH(ssh),
    .ImageWidth(iw), .ImageHeight(ih), .bus(bus), .McuCols(cols), .McuRows(rows),
    .FrameDone(fdone), .Busy(busy), .ErrOverrun(err)
  );
  always #5 clk = ~clk;

  function automatic int m_color();
    return m_seq.size() == 0 ? 0 : m_seq[m_idx];
  endfunction

  task automatic model_clear(input int s);
    m_state = s; m_idx = 0; m_infl = 0; m_stored = 0; m_conv = 0; m_cols = 0; m_rows = 0;
    m_req = 0; m_rdy = 0; m_err = 0; m_seq = {};
  endtask

  task automatic model_step(input bit r, input bit p, input bit b, input bit c);
    bit run, blk, cv, old_rdy, grey;
    int total, dw, dh;
    if (r) begin model_clear(0); return; end
    if (p) begin model_clear(1); return; end
    run = m_state == 2;
    blk = run && b;
    cv = run && c && m_infl > 0;
    total = m_cols * m_rows;
    old_rdy = m_rdy;
    m_err = m_err || (blk && !m_req);
    m_rdy = blk && m_idx == m_seq.size() - 1;
    if (blk) begin
      if (m_rdy && m_stored < total) m_stored++;
      m_idx = (m_idx + 1) % m_seq.size();
    end
    m_infl = m_infl + int'(old_rdy) - int'(cv);
    if (m_infl > BANKS) m_infl = BANKS;
    if (cv) begin
      if (m_conv == total - 1) m_state = 3;
      else m_conv++;
    end
    if (m_state == 1) begin
      grey = comp != 3;
      if (grey) m_seq = {0};
      else if (ssw == 2 && ssh == 2) m_seq = {0, 1, 2, 3, 4, 5};
      else if (ssw == 2) m_seq = {0, 1, 4, 5};
      else if (ssh == 2) m_seq = {0, 2, 4, 5};
      else m_seq = {0, 4, 5};
      dw = (!grey && ssw == 2) ? 16 : 8;
      dh = (!grey && ssh == 2) ? 16 : 8;
      m_cols = ((int'(iw) + dw - 1) / dw) % (1 << CW);
      m_rows = ((int'(ih) + dh - 1) / dh) % (1 << CW);
      m_state = (m_cols == 0 || m_rows == 0) ? 3 : 2;
    end
    m_req = m_state == 2 && (m_infl < BANKS || m_idx != 0) && m_stored < m_cols * m_rows;
  endtask

  task automatic tick();
    bit r, p, b, c;
    r = rst; p = pi; b = bus.BlockDone; c = bus.ConvertDone;
    @(posedge clk);
    model_step(r, p, b, c);
    #1;
    pi = 0; bus.BlockDone = 0; bus.ConvertDone = 0;
  endtask

  task automatic start(input logic [2:0] c, input logic [1:0] w, input logic [1:0] h, input logic [15:0] xw, input logic [15:0] xh);
    comp = c; ssw = w; ssh = h; iw = xw; ih = xh; pi = 1;
    tick(); tick();
  endtask

  task automatic blk();
    bus.BlockDone = 1; tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    n_chk++; if (bus.BlockColor !== 3'd0) begin n_fail++; $display("FAIL reset_color got %0d exp 0", bus.BlockColor); end
    n_chk++; if (bus.BlockReq !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", bus.BlockReq); end
    n_chk++; if (bus.McuReady !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b exp 0", bus.McuReady); end
    n_chk++; if ({bus.McuX, bus.McuY} !== 24'd0) begin n_fail++; $display("FAIL reset_xy got %0d/%0d exp 0/0", bus.McuX, bus.McuY); end
    n_chk++; if ({cols, rows} !== 24'd0) begin n_fail++; $display("FAIL reset_dims got %0d/%0d exp 0/0", cols, rows); end
    n_chk++; if ({fdone, busy, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {fdone, busy, err}); end
    rst = 0;
  endtask

  task automatic test_420();
    start(3'd3, 2'd2, 2'd2, 16'd32, 16'd16);
    n_chk++; if (cols !== 12'd2 || rows !== 12'd1) begin n_fail++; $display("FAIL 420_dims got %0d/%0d exp 2/1", cols, rows); end
    n_chk++; if (bus.BlockReq !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL 420_run got req=%b busy=%b exp 1/1", bus.BlockReq, busy); end
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 6; b++) begin
        n_chk++; if (bus.BlockColor !== 3'(b)) begin n_fail++; $display("FAIL 420_color got %0d exp %0d", bus.BlockColor, b); end
        bus.BlockDone = 1; tick();
        if (b == 5) begin
          n_chk++; if (bus.McuReady !== 1'b1) begin n_fail++; $display("FAIL 420_ready got %b exp 1", bus.McuReady); end
        end
        tick();
      end
      bus.ConvertDone = 1; tick();
      n_chk++; if (bus.McuX !== 12'd1) begin n_fail++; $display("FAIL 420_x got %0d exp 1", bus.McuX); end
      n_chk++; if (fdone !== 1'(m)) begin n_fail++; $display("FAIL 420_framedone got %b exp %0d", fdone, m); end
    end
    n_chk++; if (busy !== 1'b0 || bus.BlockColor !== 3'd0) begin n_fail++; $display("FAIL 420_end got busy=%b color=%0d exp 0/0", busy, bus.BlockColor); end
  endtask

  task automatic test_grey();
    start(3'd1, 2'd2, 2'd2, 16'd17, 16'd9);
    n_chk++; if (cols !== 12'd3 || rows !== 12'd2) begin n_fail++; $display("FAIL grey_dims got %0d/%0d exp 3/2", cols, rows); end
    for (int m = 0; m < 6; m++) begin
      blk();
      n_chk++; if (bus.BlockColor !== 3'd0) begin n_fail++; $display("FAIL grey_color got %0d exp 0", bus.BlockColor); end
      bus.ConvertDone = 1; tick();
      if (m == 2) begin
        n_chk++; if (bus.McuX !== 12'd0 || bus.McuY !== 12'd1) begin n_fail++; $display("FAIL grey_wrap got %0d/%0d exp 0/1", bus.McuX, bus.McuY); end
      end
    end
    n_chk++; if (fdone !== 1'b1 || bus.McuX !== 12'd2 || bus.McuY !== 12'd1) begin n_fail++; $display("FAIL grey_done got fd=%b x=%0d y=%0d exp 1/2/1", fdone, bus.McuX, bus.McuY); end
  endtask

  task automatic test_backpressure_restart();
    start(3'd3, 2'd2, 2'd1, 16'd64, 16'd8);
    for (int b = 0; b < 8; b++) blk();
    tick();
    n_chk++; if (bus.BlockReq !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL bp_full got req=%b err=%b exp 0/0", bus.BlockReq, err); end
    bus.ConvertDone = 1; tick();
    n_chk++; if (bus.BlockReq !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b exp 1", bus.BlockReq); end
    for (int b = 0; b < 4; b++) blk();
    n_chk++; if (bus.BlockReq !== 1'b0) begin n_fail++; $display("FAIL bp_refull got %b exp 0", bus.BlockReq); end
    bus.BlockDone = 1; tick();
    n_chk++; if (err !== 1'b1 || bus.BlockColor !== 3'd1) begin n_fail++; $display("FAIL bp_overrun got err=%b color=%0d exp 1/1", err, bus.BlockColor); end
    n_chk++; if (bus.McuX !== 12'd1) begin n_fail++; $display("FAIL bp_x got %0d exp 1", bus.McuX); end
    pi = 1; tick();
    n_chk++; if (busy !== 1'b1 || bus.BlockReq !== 1'b0) begin n_fail++; $display("FAIL restart_setup got busy=%b req=%b exp 1/0", busy, bus.BlockReq); end
    n_chk++; if ({bus.McuX, err, bus.BlockColor} !== 16'd0) begin n_fail++; $display("FAIL restart_clear got x=%0d err=%b color=%0d exp 0/0/0", bus.McuX, err, bus.BlockColor); end
  endtask

  task automatic test_coincident();
    start(3'd3, 2'd1, 2'd1, 16'd64, 16'd8);
    for (int b = 0; b < 5; b++) blk();
    n_chk++; if (bus.BlockReq !== 1'b1 || bus.BlockColor !== 3'd5) begin n_fail++; $display("FAIL coin_pre got req=%b color=%0d exp 1/5", bus.BlockReq, bus.BlockColor); end
    bus.BlockDone = 1; tick();
    n_chk++; if (bus.McuReady !== 1'b1 || bus.BlockReq !== 1'b1) begin n_fail++; $display("FAIL coin_ready got rdy=%b req=%b exp 1/1", bus.McuReady, bus.BlockReq); end
    bus.ConvertDone = 1; tick();
    n_chk++; if (bus.BlockReq !== 1'b1) begin n_fail++; $display("FAIL coin_req1 got %b exp 1", bus.BlockReq); end
    tick();
    n_chk++; if (bus.BlockReq !== 1'b1 || bus.McuX !== 12'd1) begin n_fail++; $display("FAIL coin_req2 got req=%b x=%0d exp 1/1", bus.BlockReq, bus.McuX); end
  endtask

  task automatic test_reset_run();
    start(3'd3, 2'd2, 2'd2, 16'd32, 16'd16);
    for (int b = 0; b < 3; b++) blk();
    rst = 1; tick(); rst = 0;
    n_chk++; if ({bus.BlockColor, bus.BlockReq, busy, cols, rows} !== 29'd0) begin n_fail++; $display("FAIL rstrun_out got color=%0d req=%b busy=%b cols=%0d rows=%0d exp all 0", bus.BlockColor, bus.BlockReq, busy, cols, rows); end
    bus.BlockDone = 1; tick(); tick();
    n_chk++; if ({bus.BlockColor, err, bus.McuReady} !== 5'd0) begin n_fail++; $display("FAIL rstrun_ignore got color=%0d err=%b rdy=%b exp 0/0/0", bus.BlockColor, err, bus.McuReady); end
  endtask

  task automatic test_random();
    logic [55:0] exp_v, act_v;
    for (int it = 0; it < 8; it++) begin
      comp = $urandom_range(0, 1) ? 3'd3 : 3'd1;
      ssw = 2'($urandom_range(1, 2));
      ssh = 2'($urandom_range(1, 2));
      iw = it == 3 ? 16'd0 : 16'($urandom_range(1, 80));
      ih = 16'($urandom_range(1, 40));
      pi = 1; tick();
      for (int cyc = 0; cyc < 4000 && m_state != 3; cyc++) begin
        bus.BlockDone = ($urandom_range(0, 19) == 0) || (bus.BlockReq && $urandom_range(0, 1) == 1);
        bus.ConvertDone = $urandom_range(0, 2) == 0;
        tick();
        exp_v = {3'(m_color()), m_req, m_rdy, 12'(m_cols > 0 ? m_conv % m_cols : 0), 12'(m_cols > 0 ? m_conv / m_cols : 0),
                 12'(m_cols), 12'(m_rows), m_state == 3, m_state == 1 || m_state == 2, m_err};
        act_v = {bus.BlockColor, bus.BlockReq, bus.McuReady, bus.McuX, bus.McuY, cols, rows, fdone, busy, err};
        n_chk++; if (act_v !== exp_v) begin n_fail++; $display("FAIL rnd_outputs it=%0d cyc=%0d got %h exp %h", it, cyc, act_v, exp_v); end
      end
      n_chk++; if (fdone !== 1'b1 || m_state != 3) begin n_fail++; $display("FAIL rnd_timeout it=%0d got framedone=%b exp 1", it, fdone); end
    end
  endtask

  initial begin
    bus.BlockDone = 0; bus.ConvertDone = 0;
    test_reset();
    test_420();
    test_grey();
    test_backpressure_restart();
    test_coincident();
    test_reset_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
